// File: rtl/iterative_muldiv_pkg.sv
// muldiv_pkg: shared types and opcode helpers for the iterative RV32M
// multiply/divide unit.
//   muldiv_op_e    - funct3 encodings of the eight M-extension operations
//   muldiv_state_e - control FSM states
//   is_div / rs1_signed / rs2_signed - opcode classification helpers
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(muldiv_op_e op);
    return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
  endfunction

  // MUL only needs the low half, which is sign-agnostic, so it runs unsigned.
  function automatic logic rs1_signed(muldiv_op_e op);
    return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  endfunction

  function automatic logic rs2_signed(muldiv_op_e op);
    return (op inside {OP_MULH, OP_DIV, OP_REM});
  endfunction

endpackage

// File: rtl/iterative_muldiv_if.sv
// iterative_muldiv_if: request/response bundle of the multiply/divide unit.
//   start, flush, mul_opcode, operand1, operand2 : requester -> unit
//   busy, done, result                           : unit -> requester
// master = execute-stage side, slave = the unit.
interface iterative_muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic            flush;
  logic [2:0]      mul_opcode;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, flush, mul_opcode, operand1, operand2,
                  input  busy, done, result);
  modport slave  (input  start, flush, mul_opcode, operand1, operand2,
                  output busy, done, result);
endinterface

// File: rtl/iterative_muldiv.sv
// iterative_muldiv: bit-serial RV32M multiply/divide unit.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - iterative_muldiv_if.slave (start/flush/opcode/operands in,
//          busy/done/result out)
// One product/quotient bit per CALC cycle; FIX applies signs and selects
// the half/quotient/remainder; DONE pulses done for one cycle.
// Build option: define MULDIV_DIV_EN to compile the divider. Without it,
// divide opcodes finish one cycle after accept with result 0.
module iterative_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  iterative_muldiv_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;

  muldiv_state_e     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;     // {hi, lo}: product, or {rem, quotient}
  logic [XLEN-1:0]   b_q, b_d;         // multiplicand or divisor magnitude
  logic [XLEN-1:0]   result_q, result_d;
  muldiv_op_e        op_q, op_d, op_in;
  logic              neg_q, neg_d;     // negate product / quotient in FIX

  logic              accept, special, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] prod;

`ifdef MULDIV_DIV_EN
  logic              s1_q, s1_d;       // dividend sign, carried to the remainder
  logic [XLEN:0]     dshift, ddiff;
  logic [XLEN-1:0]   quo, rem;
`endif

  assign op_in  = muldiv_op_e'(bus.mul_opcode);
  assign accept = (state_q == S_IDLE) && bus.start && !bus.flush;
  assign a_neg  = rs1_signed(op_in) && bus.operand1[XLEN-1];
  assign b_neg  = rs2_signed(op_in) && bus.operand2[XLEN-1];
  assign a_mag  = a_neg ? -bus.operand1 : bus.operand1;
  assign b_mag  = b_neg ? -bus.operand2 : bus.operand2;

  // Divide special cases bypass CALC entirely.
  always_comb begin
    special     = 1'b0;
    special_res = '0;
`ifdef MULDIV_DIV_EN
    if (is_div(op_in)) begin
      if (bus.operand2 == '0) begin
        special     = 1'b1;
        special_res = bus.mul_opcode[1] ? bus.operand1 : '1;
      end else if (rs1_signed(op_in) && bus.operand2 == '1 &&
                   bus.operand1 == {1'b1, {(XLEN-1){1'b0}}}) begin
        special     = 1'b1;
        special_res = bus.mul_opcode[1] ? '0 : bus.operand1;
      end
    end
`else
    special = is_div(op_in);
`endif
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.start) state_d = special ? S_DONE : S_CALC;
        S_CALC:  if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs. busy also rises combinationally with start so the hazard
  // unit sees no bubble between request and stall.
  always_comb begin
    bus.busy = (state_q != S_IDLE) || (bus.start && !bus.flush);
    bus.done = (state_q == S_DONE);
  end
  assign bus.result = result_q;

  // Datapath
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               {1'b0, (acc_q[0] ? b_q : {XLEN{1'b0}})};
    prod     = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
    s1_d     = s1_q;
    // The bit shifted out of the remainder must take part in the compare.
    dshift   = acc_q[2*XLEN-1:XLEN-1];
    ddiff    = dshift - {1'b0, b_q};
    quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = s1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
`endif
    if (accept) begin
      op_d  = op_in;
      neg_d = a_neg ^ b_neg;
      cnt_d = '0;
      // Multiply: multiplier in lo, multiplicand in b. Divide: dividend in lo.
      acc_d = {{XLEN{1'b0}}, (is_div(op_in) ? a_mag : b_mag)};
      b_d   = is_div(op_in) ? b_mag : a_mag;
`ifdef MULDIV_DIV_EN
      s1_d  = a_neg;
`endif
      if (special) result_d = special_res;
    end else begin
      case (state_q)
        S_CALC: begin
          cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_DIV_EN
          if (is_div(op_q)) begin
            if (!ddiff[XLEN]) acc_d = {ddiff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else              acc_d = {dshift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          end else
`endif
          acc_d = {msum, acc_q[XLEN-1:1]};
        end
        S_FIX: begin
          if (!bus.flush) begin
`ifdef MULDIV_DIV_EN
            if (is_div(op_q)) result_d = op_q[1] ? rem : quo;
            else
`endif
            result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
`ifdef MULDIV_DIV_EN
      s1_q     <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
`ifdef MULDIV_DIV_EN
      s1_q     <= s1_d;
`endif
    end
  end

endmodule
